// File: rtl/psum_accumulator_pkg.sv
// Shared widths and FSM encodings for the partial-sum accumulator and the MAC-array control.
package psum_accumulator_pkg;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int LEN_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/psum_accumulator_if.sv
// Product-in / result-out handshake bundle; master is the MAC side and consumer, slave is the accumulator.
interface psum_accumulator_if #(
  parameter int PROD_W = psum_accumulator_pkg::PROD_W,
  parameter int ACC_W  = psum_accumulator_pkg::ACC_W,
  parameter int LEN_W  = psum_accumulator_pkg::LEN_W
);

  logic [LEN_W-1:0]  vec_len;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              ovf;

  modport master (
    output vec_len, prod_in, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_valid, ovf
  );

  modport slave (
    input  vec_len, prod_in, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_valid, ovf
  );

endinterface

// File: rtl/psum_accumulator_add_sat.sv
// Signed ACC_W-bit adder with overflow detect; clamps to the signed range when PSUM_ACC_SAT_EN is defined.
module psum_add_sat #(
  parameter int ACC_W = psum_accumulator_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef PSUM_ACC_SAT_EN
  // Clamp direction follows the addend: only same-sign operands can overflow.
  assign sum = !ovf ? raw :
               (b[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Sums a vector of signed MAC products into one dot-product result with valid/ready output.
// Optional saturation of the running sum is enabled by defining PSUM_ACC_SAT_EN.
module psum_accumulator #(
  parameter int PROD_W = psum_accumulator_pkg::PROD_W,
  parameter int ACC_W  = psum_accumulator_pkg::ACC_W,
  parameter int LEN_W  = psum_accumulator_pkg::LEN_W
) (
  input logic               clk,
  input logic               rst,
  psum_accumulator_if.slave bus
);

  import psum_accumulator_pkg::*;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W:0]   cnt;
  logic [LEN_W:0]   len;
  logic [LEN_W:0]   cnt_next;
  logic [LEN_W:0]   len_in;
  logic             acc_valid;
  logic             prod_ready;
  logic             ovf;
  logic             accept;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  assign accept   = bus.prod_valid & prod_ready;
  assign ext      = {{(ACC_W-PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
  assign cnt_next = cnt + 1'b1;
  // A zero length encodes the full 2**LEN_W range, hence the extra count bit.
  assign len_in   = (bus.vec_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.vec_len};
  // The first product of a vector reloads the sum, so add it to zero.
  assign add_a    = (state == ST_IDLE) ? '0 : acc;

  psum_add_sat #(.ACC_W(ACC_W)) u_add (
    .a   (add_a),
    .b   (ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      cnt        <= '0;
      len        <= '0;
      acc_valid  <= 1'b0;
      prod_ready <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          prod_ready <= 1'b1;
          if (accept) begin
            acc <= add_sum;
            cnt <= {{LEN_W{1'b0}}, 1'b1};
            len <= len_in;
            ovf <= add_ovf;
            if (len_in == {{LEN_W{1'b0}}, 1'b1}) begin
              state      <= ST_DRAIN;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt_next;
            ovf <= ovf | add_ovf;
            if (cnt_next == len) begin
              state      <= ST_DRAIN;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (acc_valid && bus.acc_ready) begin
            state      <= ST_IDLE;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
            ovf        <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          acc_valid  <= 1'b0;
          prod_ready <= 1'b0;
          ovf        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_out    = acc;
  assign bus.acc_valid  = acc_valid;
  assign bus.prod_ready = prod_ready;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: default 24-bit instance plus a 17-bit instance for overflow cases.
module tb_psum_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  psum_accumulator_if #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) bus ();
  psum_accumulator_if #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) bus17 ();

  psum_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  psum_accumulator #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) dut17 (
    .clk (clk),
    .rst (rst),
    .bus (bus17.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one product after an optional idle gap and returns just after the edge that accepts it.
  task automatic send_prod(input logic [15:0] p, input int gap);
    int n;
    bus.prod_valid = 1'b0;
    repeat (gap) tick();
    bus.prod_in    = p;
    bus.prod_valid = 1'b1;
    n = 0;
    while (bus.prod_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_prod_timeout: prod_ready=%b, required 1", bus.prod_ready);
    end
    tick();
    bus.prod_valid = 1'b0;
  endtask

  task automatic take_result();
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.prod_ready !== 1'b0 || bus.acc_out !== 24'd0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b ready=%b out=%h ovf=%b, required 0 0 000000 0",
               bus.acc_valid, bus.prod_ready, bus.acc_out, bus.ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.prod_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: prod_ready=%b, required 1", bus.prod_ready);
    end
  endtask

  task automatic test_basic_sum();
    bus.vec_len = 8'd3;
    send_prod(16'd99, 0);
    send_prod(-16'sd45, 0);
    send_prod(16'd170, 0);
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'd224 || bus.ovf !== 1'b0 || bus.prod_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_sum: valid=%b out=%0d ovf=%b ready=%b, required 1 224 0 0",
               bus.acc_valid, bus.acc_out, bus.ovf, bus.prod_ready);
    end
    take_result();
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_handshake: valid=%b ready=%b, required 0 1", bus.acc_valid, bus.prod_ready);
    end
  endtask

  task automatic test_reload();
    bus.vec_len = 8'd1;
    send_prod(-16'sd128, 0);
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'hFFFF80) begin
      errors++;
      $display("[TB] FAIL len1_negative: valid=%b out=%h, required 1 ffff80", bus.acc_valid, bus.acc_out);
    end
    take_result();
    bus.vec_len = 8'd2;
    send_prod(16'd5, 1);
    send_prod(16'd6, 2);
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'd11) begin
      errors++;
      $display("[TB] FAIL reload_sum: valid=%b out=%0d, required 1 11", bus.acc_valid, bus.acc_out);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    bus.vec_len = 8'd2;
    send_prod(16'd10, 0);
    send_prod(16'd20, 0);
    bus.acc_ready  = 1'b0;
    bus.prod_in    = 16'd7;
    bus.prod_valid = 1'b1;
    bus.vec_len    = 8'd1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'd30 || bus.prod_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: valid=%b out=%0d ready=%b, required 1 30 0",
                 i, bus.acc_valid, bus.acc_out, bus.prod_ready);
      end
      tick();
    end
    take_result();
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_prod_not_taken: valid=%b ready=%b, required 0 1", bus.acc_valid, bus.prod_ready);
    end
    tick();
    bus.prod_valid = 1'b0;
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'd7) begin
      errors++;
      $display("[TB] FAIL held_prod_after: valid=%b out=%0d, required 1 7", bus.acc_valid, bus.acc_out);
    end
    take_result();
  endtask

  task automatic test_overflow();
    logic [16:0] expected;
`ifdef PSUM_ACC_SAT_EN
    expected = 17'h0FFFF;
`else
    expected = 17'h1FFFC;
`endif
    bus17.vec_len    = 8'd4;
    bus17.prod_in    = 16'd32767;
    bus17.prod_valid = 1'b1;
    repeat (4) tick();
    bus17.prod_valid = 1'b0;
    checks++;
    if (bus17.acc_valid !== 1'b1 || bus17.acc_out !== expected || bus17.ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow17: valid=%b out=%h ovf=%b, required 1 %h 1",
               bus17.acc_valid, bus17.acc_out, bus17.ovf, expected);
    end
    bus17.acc_ready = 1'b1;
    tick();
    bus17.acc_ready = 1'b0;
    checks++;
    if (bus17.ovf !== 1'b0 || bus17.acc_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: ovf=%b valid=%b, required 0 0", bus17.ovf, bus17.acc_valid);
    end
  endtask

  task automatic test_full_length();
    bus.vec_len = 8'd0;
    send_prod(16'd1, 0);
    bus.vec_len = 8'd3;
    for (int i = 1; i < 255; i++) send_prod(16'd1, int'($urandom_range(0, 2)));
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.acc_out !== 24'd255) begin
      errors++;
      $display("[TB] FAIL full_len_255: valid=%b out=%0d, required 0 255", bus.acc_valid, bus.acc_out);
    end
    send_prod(16'd1, 1);
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'd256) begin
      errors++;
      $display("[TB] FAIL full_len_256: valid=%b out=%0d, required 1 256", bus.acc_valid, bus.acc_out);
    end
    take_result();
  endtask

  task automatic test_mid_reset();
    bus.vec_len = 8'd4;
    send_prod(16'd100, 0);
    send_prod(16'd200, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.acc_out !== 24'd0 || bus.prod_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b out=%0d ready=%b, required 0 0 0",
               bus.acc_valid, bus.acc_out, bus.prod_ready);
    end
    bus.vec_len = 8'd2;
    send_prod(16'd3, 0);
    send_prod(16'd4, 0);
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 24'd7) begin
      errors++;
      $display("[TB] FAIL post_reset_sum: valid=%b out=%0d, required 1 7", bus.acc_valid, bus.acc_out);
    end
    take_result();
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.vec_len      = '0;
    bus.prod_in      = '0;
    bus.prod_valid   = 1'b0;
    bus.acc_ready    = 1'b0;
    bus17.vec_len    = '0;
    bus17.prod_in    = '0;
    bus17.prod_valid = 1'b0;
    bus17.acc_ready  = 1'b0;
    test_reset();
    test_basic_sum();
    test_reload();
    test_back_to_back();
    test_overflow();
    test_full_length();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
